inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
- Multi-cycle instruction fetch stage directly upstream of the RV32E core datapath.
- Owns the fetch PC and issues one read per instruction on a valid/ready instruction-memory port.
- Presents the returned word to the core as inst/inst_valid and holds it until the core accepts it with inst_ready.
- Applies the core's jump redirect at acceptance, and supports an asynchronous-to-pipeline flush (trap/redirect) that discards any in-flight fetch.

Parameters:
- RESET_PC, 32'h8000_0000, fetch address after reset.
- WIDTH, 32, address/data width; equals the core word width.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- imem_araddr  output  WIDTH  fetch address
- imem_arvalid  output  1  address request valid
- imem_arready  input  1  memory accepts address
- imem_rdata  input  WIDTH  returned instruction word
- imem_rresp  input  2  response code; 0 = OK, nonzero = bus error
- imem_rvalid  input  1  read data valid
- imem_rready  output  1  fetch unit accepts data
- inst  output  WIDTH  instruction to core
- inst_pc  output  WIDTH  PC of inst
- inst_err  output  1  inst is a fetch fault (bus error or misaligned PC)
- inst_valid  output  1  inst/inst_pc/inst_err valid
- inst_ready  input  1  core consumes current instruction
- jump_sig  input  1  with inst_ready: next PC = jump_addr
- jump_addr  input  WIDTH  jump target
- flush_valid  input  1  discard everything, restart at flush_pc
- flush_pc  input  WIDTH  flush target

Behaviour:
- Single clock; reset is synchronous and active-high, on clk and rst.
- While rst=1 at a clk edge:
  - pc <= RESET_PC; state <= S_REQ; discard <= 0.
  - inst, inst_pc <= 0; inst_err <= 0.
  - Outputs: imem_arvalid=0, imem_rready=0, inst_valid=0.
  - Reset overrides everything, including a mid-transaction WAIT. Any response arriving later is ignored because rready=0 outside WAIT; the memory side is reset by the same rst.
- FSM states: S_REQ, S_WAIT, S_HOLD.
- S_REQ:
  - If pc[1:0]==0: imem_arvalid=1, imem_araddr=pc. araddr is held stable while arvalid=1 and arvalid is never withdrawn before arready. On arvalid&&arready, go to S_WAIT.
  - If pc[1:0]!=0: no bus request. Next cycle go to S_HOLD with inst=0, inst_pc=pc, inst_err=1.
- S_WAIT:
  - imem_rready=1.
  - On rvalid with discard=0: inst<=rdata, inst_pc<=pc, inst_err<=(rresp!=0), go to S_HOLD.
  - On rvalid with discard=1: drop data, discard<=0, go to S_REQ; pc already holds the flush target.
- S_HOLD:
  - inst_valid=1; inst/inst_pc/inst_err stable.
  - On inst_ready: pc <= jump_sig ? jump_addr : pc+4 (32-bit wrap; 0xFFFF_FFFC+4=0), go to S_REQ.
- Latency:
  - rvalid cycle N gives inst_valid at N+1.
  - inst_ready accept at cycle M gives arvalid at M+1.
  - Minimum 3 cycles per instruction with zero-wait memory.
- flush_valid (priority over everything except rst):
  - S_HOLD: inst_valid drops next cycle, pc<=flush_pc, go to S_REQ. inst_ready in the same cycle is ignored and jump_sig has no effect.
  - S_REQ with request not yet accepted: pc<=flush_pc, discard<=1. arvalid stays up with the old address until accepted. Exception: if the old pc was misaligned (no request outstanding), restart at flush_pc directly with discard=0.
  - S_REQ with arready in the same cycle: pc<=flush_pc, discard<=1, go to S_WAIT.
  - S_WAIT, with or without rvalid in the same cycle: pc<=flush_pc. If rvalid is in that cycle, drop the data and go to S_REQ with discard=0. Otherwise set discard<=1.
  - Repeated flushes: the latest flush_pc wins; only one outstanding request ever exists.
- inst_ready outside S_HOLD and jump_sig without inst_ready are ignored.
- An erroneous response is still delivered (inst=rdata, inst_err=1); the core decides trap handling.

Test Plan:
- Reset release, zero-wait memory returning 0x00000413 at 0x80000000 and 0x00100513 at 0x80000004, inst_ready tied 1 -> araddr 0x80000000 then 0x80000004; inst_valid pulses with matching inst_pc; 3-cycle spacing.
- Memory arready delayed 4 cycles and rvalid delayed 5 -> araddr constant throughout; inst appears exactly 1 cycle after rvalid; no duplicate request.
- In S_HOLD at pc 0x80000010, inst_ready=1, jump_sig=1, jump_addr=0x80000100 -> next araddr=0x80000100.
- flush_valid with flush_pc=0x80000200 during S_WAIT of a fetch to 0x80000008 -> the response for 0x80000008 is dropped (no inst_valid); next araddr=0x80000200.
- Flush in the same cycle as inst_ready+jump_sig in S_HOLD -> flush target used; jump ignored.
- Jump to 0x80000102 -> no arvalid; inst_valid with inst_err=1, inst=0, inst_pc=0x80000102. Separately, rresp=2 -> inst_err=1. Separately, rst asserted during S_WAIT -> next fetch at 0x80000000.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - multi-cycle instruction fetch stage with jump redirect and flush
module inst_fetch_unit #(
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] imem_araddr,
    output logic             imem_arvalid,
    input  logic             imem_arready,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic [1:0]       imem_rresp,
    input  logic             imem_rvalid,
    output logic             imem_rready,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc,
    output logic             inst_err,
    output logic             inst_valid,
    input  logic             inst_ready,
    input  logic             jump_sig,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic             flush_valid,
    input  logic [WIDTH-1:0] flush_pc
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] req_addr_q;
    logic             discard_q, discard_d;
    logic [WIDTH-1:0] inst_q, inst_d;
    logic [WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic             inst_err_q, inst_err_d;
    logic             req_issue;

    // A flushed-but-unaccepted request keeps presenting its original address
    // from req_addr_q while pc already holds the flush target.
    assign req_issue    = discard_q || (pc_q[1:0] == 2'b00);
    assign imem_arvalid = !rst && (state_q == S_REQ) && req_issue;
    assign imem_araddr  = discard_q ? req_addr_q : pc_q;
    assign imem_rready  = !rst && (state_q == S_WAIT);
    assign inst_valid   = !rst && (state_q == S_HOLD);
    assign inst         = inst_q;
    assign inst_pc      = inst_pc_q;
    assign inst_err     = inst_err_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        inst_err_d = inst_err_q;
        case (state_q)
            S_REQ: begin
                if (req_issue) begin
                    if (imem_arready) begin
                        state_d = S_WAIT;
                    end
                    if (flush_valid) begin
                        pc_d      = flush_pc;
                        discard_d = 1'b1;
                    end
                end else if (flush_valid) begin
                    pc_d = flush_pc;
                end else begin
                    state_d    = S_HOLD;
                    inst_d     = '0;
                    inst_pc_d  = pc_q;
                    inst_err_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (flush_valid) begin
                    pc_d = flush_pc;
                    if (imem_rvalid) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (discard_q) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        state_d    = S_HOLD;
                        inst_d     = imem_rdata;
                        inst_pc_d  = pc_q;
                        inst_err_d = (imem_rresp != 2'b00);
                    end
                end
            end
            S_HOLD: begin
                if (flush_valid) begin
                    pc_d    = flush_pc;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_d    = jump_sig ? jump_addr : pc_q + WIDTH'(4);
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            discard_q  <= 1'b0;
            inst_q     <= '0;
            inst_pc_q  <= '0;
            inst_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            inst_err_q <= inst_err_d;
            if (state_q == S_REQ && !discard_q) begin
                req_addr_q <= pc_q;
            end
        end
    end

endmodule
